// File: rtl/general1.sv
// Shared types and helpers for the multi-channel PWM controller.
// Holds the PWM alignment type and the ns-to-clocks conversion.
package General1;

    typedef enum logic {
        PWM_FRONT,
        PWM_BACK
    } pwm_type_e;

    function automatic int ns_to_clocks(input int ns, input int clk_ns);
        return ns / clk_ns;
    endfunction

endpackage

// File: rtl/button_repeat.sv
// Button debounce filter with optional hold-to-repeat.
// Raw active-low input in, one-clock press events out.
module button_repeat #(
    parameter int FT           = 5,
    parameter int PT           = 125,
    parameter int RT           = 75,
    parameter bit RepeatEnable = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_ni,
    output logic event_o
);

    localparam int FW   = $clog2(FT + 1);
    localparam int RMAX = (PT > RT) ? PT : RT;
    localparam int RW   = $clog2(RMAX + 1);

    logic          level_q;
    logic [FW-1:0] fcnt_q;
    logic [RW-1:0] rcnt_q;
    logic          pause_q;
    logic          event_q;
    logic [RW-1:0] rlim;

    // first repeat waits the long pause, later ones the short spacing
    assign rlim    = pause_q ? RW'(PT - 1) : RW'(RT - 1);
    assign event_o = event_q;

    // level filter, press detection and repeat timer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= 1'b1;
            fcnt_q  <= '0;
            rcnt_q  <= '0;
            pause_q <= 1'b1;
            event_q <= 1'b0;
        end else begin
            event_q <= 1'b0;
            if (btn_ni == level_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q == FW'(FT - 1)) begin
                fcnt_q  <= '0;
                level_q <= btn_ni;
                if (!btn_ni) begin
                    event_q <= 1'b1;
                    rcnt_q  <= '0;
                    pause_q <= 1'b1;
                end
            end else begin
                fcnt_q <= fcnt_q + 1'b1;
            end
            if (RepeatEnable && !level_q) begin
                if (rcnt_q == rlim) begin
                    event_q <= 1'b1;
                    rcnt_q  <= '0;
                    pause_q <= 1'b0;
                end else begin
                    rcnt_q <= rcnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_pwm_control.sv
// Multi-channel phase-staggered PWM with button-driven duty control.
// Shadowed duties reload at each channel's own phase zero.
module multi_pwm_control
    import General1::*;
#(
    parameter int        Channels           = 4,
    parameter int        Size               = 8,
    parameter int        ClockPeriod_ns     = 20,
    parameter int        FilterPeriod_ns    = 100,
    parameter int        PauseInterval_ns   = 2500,
    parameter int        RepeatsInterval_ns = 1500,
    parameter pwm_type_e PWMType            = PWM_BACK
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        Button_Up,
    input  logic                        Button_Down,
    input  logic                        Button_Select,
    output logic [Channels-1:0]         PWM,
    output logic                        Synch,
    output logic [$clog2(Channels)-1:0] SelChannel,
    output logic [Size-1:0]             SelDuty
);

    localparam int CW   = $clog2(Channels);
    localparam int SW   = Size + 1;
    localparam int FT   = ns_to_clocks(FilterPeriod_ns, ClockPeriod_ns);
    localparam int PT   = ns_to_clocks(PauseInterval_ns, ClockPeriod_ns);
    localparam int RT   = ns_to_clocks(RepeatsInterval_ns, ClockPeriod_ns);
    localparam int PI   = 2 ** Size - 1;
    localparam int STEP = PI / Channels;
    localparam logic [Size-1:0] P = Size'(PI);

    logic                up_ev, dn_ev, sel_ev;
    logic [Size-1:0]     m_q, m_d;
    logic [Size-1:0]     ck_q  [Channels];
    logic [Size-1:0]     ck_d  [Channels];
    logic [Size-1:0]     req_q [Channels];
    logic [Size-1:0]     req_d [Channels];
    logic [Size-1:0]     act_q [Channels];
    logic [Size-1:0]     act_d [Channels];
    logic [Channels-1:0] pwm_q, pwm_d;
    logic                synch_q, synch_d;
    logic [CW-1:0]       sel_q, sel_d;

    function automatic logic [Size-1:0] phase(input logic [Size-1:0] m,
                                              input int k);
        logic [SW-1:0] s;
        s = {1'b0, m} + SW'(k * STEP);
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[Size-1:0];
    endfunction

    button_repeat #(.FT(FT), .PT(PT), .RT(RT), .RepeatEnable(1'b1)) u_up (
        .clk_i(Clock), .rst_i(Reset), .btn_ni(Button_Up), .event_o(up_ev)
    );
    button_repeat #(.FT(FT), .PT(PT), .RT(RT), .RepeatEnable(1'b1)) u_dn (
        .clk_i(Clock), .rst_i(Reset), .btn_ni(Button_Down), .event_o(dn_ev)
    );
    button_repeat #(.FT(FT), .PT(PT), .RT(RT), .RepeatEnable(1'b0)) u_sel (
        .clk_i(Clock), .rst_i(Reset), .btn_ni(Button_Select), .event_o(sel_ev)
    );

    // next-state for counters, duties, selection and PWM compare
    always_comb begin
        m_d     = (m_q == P - 1'b1) ? '0 : m_q + 1'b1;
        synch_d = (m_d == '0);
        sel_d   = sel_q;
        pwm_d   = '0;
        if (sel_ev) sel_d = (sel_q == CW'(Channels - 1)) ? '0 : sel_q + 1'b1;
        for (int k = 0; k < Channels; k++) begin
            ck_d[k]  = phase(m_d, k);
            req_d[k] = req_q[k];
            // at phase zero the new duty is taken and also used this period
            act_d[k] = (ck_q[k] == '0) ? req_q[k] : act_q[k];
            if (PWMType == PWM_FRONT) pwm_d[k] = (ck_q[k] < act_d[k]);
            else                      pwm_d[k] = (ck_q[k] >= P - act_d[k]);
        end
        if (up_ev && !dn_ev && req_q[sel_q] != P)
            req_d[sel_q] = req_q[sel_q] + 1'b1;
        if (dn_ev && !up_ev && req_q[sel_q] != '0)
            req_d[sel_q] = req_q[sel_q] - 1'b1;
    end

    // state registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            m_q     <= '0;
            synch_q <= 1'b0;
            sel_q   <= '0;
            pwm_q   <= '0;
            for (int k = 0; k < Channels; k++) begin
                ck_q[k]  <= '0;
                req_q[k] <= '0;
                act_q[k] <= '0;
            end
        end else begin
            m_q     <= m_d;
            synch_q <= synch_d;
            sel_q   <= sel_d;
            pwm_q   <= pwm_d;
            for (int k = 0; k < Channels; k++) begin
                ck_q[k]  <= ck_d[k];
                req_q[k] <= req_d[k];
                act_q[k] <= act_d[k];
            end
        end
    end

    assign PWM        = pwm_q;
    assign Synch      = synch_q;
    assign SelChannel = sel_q;
    assign SelDuty    = req_q[sel_q];

endmodule

// File: tb/tb_multi_pwm_control.sv
// Self-checking bench for multi_pwm_control.
// Channels=4, Size=4, P=15, FT=5, PT=125, RT=75, Back-aligned.
module tb_multi_pwm_control;
    import General1::*;

    localparam int CH = 4;
    localparam int SZ = 4;
    localparam int P  = 15;
    localparam int FT = 5;
    localparam int PT = 125;
    localparam int RT = 75;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          up_n = 1'b1;
    logic          dn_n = 1'b1;
    logic          sel_n = 1'b1;
    logic [CH-1:0] pwm;
    logic          synch;
    logic [1:0]    selch;
    logic [SZ-1:0] seld;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        string name;
        int    sel;
        int    duty;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int ch;
        int duty;
        int highs;
        int rise;
    } vec_t;
    vec_t vecs[CH];

    int            chg_q[$];
    logic [SZ-1:0] prev_duty = '0;
    int            mdl_sel = 0;
    int            mdl_duty[CH];
    int            hits[CH];
    logic [CH-1:0] win[P];

    multi_pwm_control #(
        .Channels(CH), .Size(SZ), .ClockPeriod_ns(20),
        .FilterPeriod_ns(100), .PauseInterval_ns(2500),
        .RepeatsInterval_ns(1500), .PWMType(PWM_BACK)
    ) dut (
        .Clock(clk), .Reset(rst), .Button_Up(up_n), .Button_Down(dn_n),
        .Button_Select(sel_n), .PWM(pwm), .Synch(synch),
        .SelChannel(selch), .SelDuty(seld)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // record the cycle of every SelDuty change
    always @(negedge clk) begin
        if (seld != prev_duty) chg_q.push_back(cyc);
        prev_duty = seld;
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mdl_sel = 0;
        for (int k = 0; k < CH; k++) mdl_duty[k] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic sb_push(input string nm);
        exp_t e;
        e.name = nm;
        e.sel  = mdl_sel;
        e.duty = mdl_duty[mdl_sel];
        sbq.push_back(e);
    endtask

    task automatic sb_drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check({e.name, "_sel"}, int'(selch), e.sel);
            check({e.name, "_duty"}, int'(seld), e.duty);
        end
    endtask

    // kind: 0 up, 1 down, 2 select, 3 up+down together
    task automatic press(input int kind, input int n, input bit ev,
                         input string nm);
        if (kind == 0 || kind == 3) up_n = 1'b0;
        if (kind == 1 || kind == 3) dn_n = 1'b0;
        if (kind == 2) sel_n = 1'b0;
        step(n);
        up_n  = 1'b1;
        dn_n  = 1'b1;
        sel_n = 1'b1;
        step(FT + 10);
        if (ev) begin
            if (kind == 0 && mdl_duty[mdl_sel] < P) mdl_duty[mdl_sel]++;
            if (kind == 1 && mdl_duty[mdl_sel] > 0) mdl_duty[mdl_sel]--;
            if (kind == 2) mdl_sel = (mdl_sel + 1) % CH;
        end
        sb_push(nm);
        sb_drain();
    endtask

    task automatic count_highs(input int n);
        for (int k = 0; k < CH; k++) hits[k] = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int k = 0; k < CH; k++) hits[k] += int'(pwm[k]);
        end
    endtask

    task automatic wait_synch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (synch) begin
                ok = 1'b1;
                break;
            end
        end
        check("synch_seen", int'(ok), 1);
    endtask

    initial begin
        int  c0;
        int  d;
        int  sel_exp[5];
        int  hi;
        int  rise;
        int  n;
        int  pw;
        bit  ok;

        vecs[0] = '{0, 4, 4, 12};
        vecs[1] = '{1, 4, 4, 9};
        vecs[2] = '{2, 4, 4, 6};
        vecs[3] = '{3, 4, 4, 3};
        sel_exp = '{1, 2, 3, 0, 1};
        model_clear();

        step(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_pwm", int'(pwm), 0);
        check("rst_synch", int'(synch), 0);
        check("rst_selch", int'(selch), 0);
        check("rst_seld", int'(seld), 0);

        step(1);
        chg_q.delete();
        c0 = cyc;
        press(0, 20, 1'b1, "up_short");
        check("up_short_events", chg_q.size(), 1);
        if (chg_q.size() > 0) begin
            d = chg_q[0] - c0;
            check("up_short_latency_ok", int'(d >= FT && d <= FT + 4), 1);
        end

        do_reset();
        step(3);
        chg_q.delete();
        c0 = cyc;
        up_n = 1'b0;
        step(400);
        up_n = 1'b1;
        step(20);
        check("hold_events", chg_q.size(), 5);
        if (chg_q.size() == 5) begin
            check("hold_gap1", chg_q[1] - chg_q[0], PT);
            check("hold_gap2", chg_q[2] - chg_q[1], RT);
            check("hold_gap3", chg_q[3] - chg_q[2], RT);
            check("hold_gap4", chg_q[4] - chg_q[3], RT);
        end
        mdl_duty[0] = 5;
        sb_push("hold400");
        sb_drain();

        up_n = 1'b0;
        step(1200);
        up_n = 1'b1;
        step(20);
        mdl_duty[0] = 15;
        sb_push("hold_sat");
        sb_drain();
        press(0, 20, 1'b1, "up_at_max");
        step(40);
        count_highs(30);
        check("full_duty_pwm0_highs", hits[0], 30);

        press(1, 3, 1'b0, "dn_glitch");
        press(3, 20, 1'b1, "up_dn_same");
        press(1, 20, 1'b1, "dn_once");

        do_reset();
        step(2);
        press(1, 20, 1'b1, "dn_at_zero");

        do_reset();
        up_n = 1'b0;
        step(20);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        model_clear();
        check("held_rst_cleared", int'(seld), 0);
        step(20);
        up_n = 1'b1;
        step(15);
        check("held_rst_fresh_event", int'(seld), 1);

        do_reset();
        step(2);
        for (int i = 0; i < 5; i++) begin
            press(2, 20, 1'b1, "select");
            check("select_seq", int'(selch), sel_exp[i]);
        end
        for (int i = 0; i < 4; i++) press(0, 20, 1'b1, "ch1_up");
        step(40);
        count_highs(30);
        check("ch1_only_pwm0", hits[0], 0);
        check("ch1_only_pwm1", hits[1], 8);
        check("ch1_only_pwm2", hits[2], 0);
        check("ch1_only_pwm3", hits[3], 0);

        do_reset();
        step(2);
        for (int i = 0; i < CH; i++) begin
            n = 0;
            while (mdl_sel != vecs[i].ch && n < CH) begin
                press(2, 20, 1'b1, "tbl_sel");
                n++;
            end
            for (int j = 0; j < vecs[i].duty; j++)
                press(0, 20, 1'b1, "tbl_up");
        end
        step(40);
        wait_synch(ok);
        win[0] = pwm;
        n = 0;
        for (int j = 1; j < P; j++) begin
            @(negedge clk);
            win[j] = pwm;
            n += int'(synch);
        end
        @(negedge clk);
        check("synch_none_inside", n, 0);
        check("synch_period15", int'(synch), 1);
        for (int i = 0; i < CH; i++) begin
            hi   = 0;
            rise = -1;
            for (int j = 0; j < P; j++) begin
                hi += int'(win[j][vecs[i].ch]);
                if (rise < 0 && win[j][vecs[i].ch] &&
                    !win[(j + P - 1) % P][vecs[i].ch]) rise = j;
            end
            check($sformatf("tbl_ch%0d_highs", vecs[i].ch), hi, vecs[i].highs);
            check($sformatf("tbl_ch%0d_rise", vecs[i].ch), rise, vecs[i].rise);
        end

        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        check("midrst_pwm", int'(pwm), 0);
        check("midrst_synch", int'(synch), 0);
        check("midrst_seld", int'(seld), 0);
        check("midrst_selch", int'(selch), 0);
        n  = -1;
        pw = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            pw += int'(pwm != '0);
            if (synch) begin
                n = i;
                break;
            end
        end
        check("midrst_first_synch", n, 14);
        check("midrst_no_pulse", pw, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_pwm_control.md
MULTI_PWM_CONTROL -- requirements
Module: multi_pwm_control

Interface
REQ-001 Channels, 4, number of PWM outputs, 2..16.
REQ-002 Size, 8, duty width in bits; PWM period P = 2**Size-1 clocks.
REQ-003 ClockPeriod_ns, 20, clock period.
REQ-004 FilterPeriod_ns, 100, debounce stability time; FT = FilterPeriod_ns/ClockPeriod_ns clocks.
REQ-005 PauseInterval_ns, 2500, hold time before first auto-repeat; PT = PauseInterval_ns/ClockPeriod_ns clocks.
REQ-006 RepeatsInterval_ns, 1500, auto-repeat spacing; RT = RepeatsInterval_ns/ClockPeriod_ns clocks.
REQ-007 PWMType, "Back", "Front" = high at period start, "Back" = high at period end.
REQ-008 Clock  input  1  single clock; all logic on rising edge.
REQ-009 Reset  input  1  synchronous, active-high.
REQ-010 Button_Up  input  1  active-low, raw, increments selected duty.
REQ-011 Button_Down  input  1  active-low, raw, decrements selected duty.
REQ-012 Button_Select  input  1  active-low, raw, advances selected channel.
REQ-013 PWM  output  Channels  PWM outputs, bit k = channel k.
REQ-014 Synch  output  1  one-clock pulse at master period start.
REQ-015 SelChannel  output  $clog2(Channels)  selected channel index.
REQ-016 SelDuty  output  Size  requested duty of selected channel.

Function
REQ-017 Each button is filtered: a level is accepted only after FT consecutive identical samples.
REQ-018 An accepted press (high-to-low) SHALL emit a one-clock event on the clock after acceptance.
REQ-019 Up/Down held: further events at PT clocks after the first event, then every RT clocks, until accepted release.
REQ-020 Select SHALL NOT auto-repeat; one event per accepted press.
REQ-021 Up event: requested duty of selected channel +1, saturating at 2**Size-1 (no wrap).
REQ-022 Down event: requested duty -1, saturating at 0 (no wrap).
REQ-023 Up and Down events in the same clock: no change.
REQ-024 Select event: SelChannel +1, wrapping Channels-1 -> 0; coincident Up/Down applies to the old channel.
REQ-025 Duty registers update on the clock after the event; SelDuty is combinational from registers and SelChannel.
REQ-026 Master counter M counts 0..P-1 and wraps; Synch = 1 in the clock when M = 0.
REQ-027 Channel k phase Ck = (M + k*floor(P/Channels)) mod P.
REQ-028 Channel k active duty is loaded from its requested duty only when Ck = 0 (glitch-free shadow update).
REQ-029 "Front": PWM[k] = 1 iff Ck < active duty; "Back": PWM[k] = 1 iff Ck >= P - active duty.
REQ-030 Duty 0 -> constant 0; duty 2**Size-1 (= P) -> constant 1; PWM outputs registered, one clock after Ck.

Reset
REQ-031 Reset in any clock: M, all Ck, requested and active duties, SelChannel, PWM, Synch = 0 on next edge.
REQ-032 Reset returns filters to released state and clears repeat timers; a button held through reset is re-accepted after FT clocks and yields a fresh event.
REQ-033 Reset mid-period: no partial-period PWM pulse after reset deasserts; first Synch at M = 0.

Structure
REQ-034 PWMType enum and ns-to-clocks function reside in the shared package General1.
REQ-035 Filtering and auto-repeat in one sub-module, button_repeat, parameterised by RepeatEnable, instantiated three times.

Verification (Channels=4, Size=4, P=15, FT=5, PT=125, RT=75)
REQ-036 Up low 20 clocks -> one event, SelDuty 0->1, no repeat.
REQ-037 Up held 400 clocks -> events at press+0, +125, +200, +275, +350; SelDuty = 5; held further to saturate -> stays 15, PWM[0] constant 1.
REQ-038 Up glitch low 3 clocks -> no event; Up+Down pressed same clock -> SelDuty unchanged.
REQ-039 Select pressed 5 times -> SelChannel 1,2,3,0,1; Up on channel 1 changes PWM[1] only, from its next phase-0 clock.
REQ-040 Duty 4, "Back" -> PWM[k] high 4 of every 15 clocks, channel k offset 3k clocks; Synch every 15 clocks.
REQ-041 Reset 1 clock mid-period with duties nonzero -> all outputs 0 next clock, SelDuty 0, SelChannel 0.
